// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//   Pipeline sequencer for the 5-stage core. It produces the write enables and
//   flushes for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the
//   PC enable. Its inputs are the cache handshakes and the per-stage hazard
//   information. It covers these cases:
//     - dmem wait freeze
//     - load-use bubble
//     - branch/jump squash
//     - icache-miss bubble
//     - halt drain
//   It also keeps saturating stall/flush performance counters.
//
// Ports
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   ihit, dhit               imem / dmem access completes this cycle
//   mem_dreq                 EX/MEM stage holds a load or store
//   mem_brtaken              EX/MEM stage holds a taken branch
//   ex_jump                  ID/EX stage holds a jump
//   ex_memread, ex_rt        ID/EX stage holds a load and its destination
//   id_rs, id_rt             source fields of the instruction in IF/ID
//   wb_halt                  MEM/WB stage holds a halt
//   pc_en                    PC write enable
//   *_wen / *_flush          pipeline register write enable / NOP load
//   dwait                    high in every DWAIT cycle
//   halted                   sticky halt indication
//   stall_cnt, flush_cnt     saturating performance counters
// -----------------------------------------------------------------------------
module hazard_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dreq,
  input  logic             mem_brtaken,
  input  logic             ex_jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_wen,
  output logic             idex_wen,
  output logic             exmem_wen,
  output logic             memwb_wen,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             dwait,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Bundle of all pipeline control outputs, so that each rule assigns one value.
  typedef struct packed {
    logic pc_en;
    logic ifid_wen;
    logic idex_wen;
    logic exmem_wen;
    logic memwb_wen;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE = 9'b0_0000_0000;
  localparam ctrl_t CTRL_RESET  = 9'b0_0000_1111;
  localparam ctrl_t CTRL_HALT   = 9'b0_0000_1110;  // MEM/WB keeps the halt
  localparam ctrl_t CTRL_BRANCH = 9'b1_1111_1110;
  localparam ctrl_t CTRL_JUMP   = 9'b1_1111_1000;
  localparam ctrl_t CTRL_LDUSE  = 9'b0_0111_0100;
  localparam ctrl_t CTRL_IMISS  = 9'b0_1111_1000;
  localparam ctrl_t CTRL_ADV    = 9'b1_1111_0000;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_r;
  state_t state_next_s;
  ctrl_t  adv_s;
  ctrl_t  ctrl_s;
  logic   load_use_s;
  logic   redirect_s;
  logic   flush_inc_s;
  logic   stall_inc_s;
  logic   dwait_s;
  logic   halted_s;

  // Load-use hazard: a load in EX writes a nonzero register read by the instruction in ID.
  always_comb begin
    load_use_s = 1'b0;
    if (ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Rules for a cycle in which the memory stage can advance (branch, jump, load-use, imiss, normal).
  always_comb begin
    adv_s      = CTRL_ADV;
    redirect_s = 1'b0;
    if (mem_brtaken) begin
      adv_s      = CTRL_BRANCH;
      redirect_s = 1'b1;
    end else if (ex_jump) begin
      adv_s      = CTRL_JUMP;
      redirect_s = 1'b1;
    end else if (load_use_s) begin
      adv_s = CTRL_LDUSE;
    end else if (!ihit) begin
      adv_s = CTRL_IMISS;
    end else begin
      adv_s = CTRL_ADV;
    end
  end

  // Next-state and output selection per state; reset overrides everything.
  always_comb begin
    state_next_s = state_r;
    ctrl_s       = CTRL_FREEZE;
    flush_inc_s  = 1'b0;
    dwait_s      = 1'b0;
    halted_s     = 1'b0;
    if (RST) begin
      state_next_s = ST_RUN;
      ctrl_s       = CTRL_RESET;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (wb_halt) begin
            ctrl_s       = CTRL_HALT;
            state_next_s = ST_HALT;
          end else if (mem_dreq && !dhit) begin
            // The freeze holds EX/MEM and ID/EX, so any redirect is taken later.
            ctrl_s       = CTRL_FREEZE;
            state_next_s = ST_DWAIT;
          end else begin
            ctrl_s      = adv_s;
            flush_inc_s = redirect_s;
          end
        end
        ST_DWAIT: begin
          dwait_s = 1'b1;
          if (dhit) begin
            ctrl_s       = adv_s;
            flush_inc_s  = redirect_s;
            state_next_s = ST_RUN;
          end else begin
            ctrl_s = CTRL_FREEZE;
          end
        end
        ST_HALT: begin
          ctrl_s   = CTRL_FREEZE;
          halted_s = 1'b1;
        end
        default: begin
          ctrl_s       = CTRL_RESET;
          state_next_s = ST_RUN;
        end
      endcase
    end
  end

  // Stall cycles are counted only while the core is live (RUN or DWAIT).
  always_comb begin
    stall_inc_s = 1'b0;
    if (!RST && ((state_r == ST_RUN) || (state_r == ST_DWAIT)) && !ctrl_s.pc_en) begin
      stall_inc_s = 1'b1;
    end else begin
      stall_inc_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Saturating stall counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (stall_inc_s && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  // Saturating redirect counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flush_cnt <= {CNT_W{1'b0}};
    end else if (flush_inc_s && (flush_cnt != CNT_MAX)) begin
      flush_cnt <= flush_cnt + CNT_ONE;
    end else begin
      flush_cnt <= flush_cnt;
    end
  end

  assign pc_en       = ctrl_s.pc_en;
  assign ifid_wen    = ctrl_s.ifid_wen;
  assign idex_wen    = ctrl_s.idex_wen;
  assign exmem_wen   = ctrl_s.exmem_wen;
  assign memwb_wen   = ctrl_s.memwb_wen;
  assign ifid_flush  = ctrl_s.ifid_flush;
  assign idex_flush  = ctrl_s.idex_flush;
  assign exmem_flush = ctrl_s.exmem_flush;
  assign memwb_flush = ctrl_s.memwb_flush;
  assign dwait       = dwait_s;
  assign halted      = halted_s;

endmodule

// File: tb/tb_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hazard_sequencer
//   Directed bench for hazard_sequencer. The control outputs are compared as
//   one 9-bit vector in this order:
//     {pc_en, ifid_wen, idex_wen, exmem_wen, memwb_wen,
//      ifid_flush, idex_flush, exmem_flush, memwb_flush}
//   The combinational outputs are sampled 1 ns after the inputs are driven.
//   The counters are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, mem_dreq, mem_brtaken, ex_jump, ex_memread, wb_halt;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic        pc_en, ifid_wen, idex_wen, exmem_wen, memwb_wen;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        dwait, halted;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLK = ~CLK;

  hazard_sequencer #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .mem_brtaken(mem_brtaken), .ex_jump(ex_jump), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_wen(ifid_wen), .idex_wen(idex_wen),
    .exmem_wen(exmem_wen), .memwb_wen(memwb_wen), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .dwait(dwait), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  wire [8:0] ctrl = {pc_en, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush};

  localparam logic [8:0] C_RESET  = 9'b0_0000_1111;
  localparam logic [8:0] C_ADV    = 9'b1_1111_0000;
  localparam logic [8:0] C_FREEZE = 9'b0_0000_0000;
  localparam logic [8:0] C_LDUSE  = 9'b0_0111_0100;
  localparam logic [8:0] C_BRANCH = 9'b1_1111_1110;
  localparam logic [8:0] C_JUMP   = 9'b1_1111_1000;
  localparam logic [8:0] C_IMISS  = 9'b0_1111_1000;
  localparam logic [8:0] C_HALT   = 9'b0_0000_1110;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_dreq = 1'b0; mem_brtaken = 1'b0;
    ex_jump = 1'b0; ex_memread = 1'b0; wb_halt = 1'b0;
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    ihit = 1'b0;
    // T1: reset for two cycles
    #1;
    check("rst_ctrl0", {23'd0, ctrl}, {23'd0, C_RESET});
    check("rst_dwait", {31'd0, dwait}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    tick();
    check("rst_ctrl1", {23'd0, ctrl}, {23'd0, C_RESET});
    tick();
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
    RST = 1'b0; ihit = 1'b1;
    #1;
    check("run_adv", {23'd0, ctrl}, {23'd0, C_ADV});
    tick();

    // T2: load-use on rs, then on rt, then the ex_rt==0 exemption
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd2;
    #1;
    check("lduse_rs_ctrl", {23'd0, ctrl}, {23'd0, C_LDUSE});
    tick();
    check("lduse_stall1", stall_cnt, 32'd1);
    ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7;
    #1;
    check("lduse_rt_ctrl", {23'd0, ctrl}, {23'd0, C_LDUSE});
    tick();
    check("lduse_stall2", stall_cnt, 32'd2);
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    check("lduse_r0_ctrl", {23'd0, ctrl}, {23'd0, C_ADV});
    tick();
    check("lduse_r0_stall", stall_cnt, 32'd2);
    idle_inputs();

    // T3: dmem wait of three cycles, advance on the fourth (stall 2 + 3 = 5)
    mem_dreq = 1'b1; dhit = 1'b0;
    #1;
    check("dw_c1_ctrl", {23'd0, ctrl}, {23'd0, C_FREEZE});
    tick();
    check("dw_c2_ctrl", {23'd0, ctrl}, {23'd0, C_FREEZE});
    check("dw_c2_dwait", {31'd0, dwait}, 32'd1);
    tick();
    check("dw_c3_ctrl", {23'd0, ctrl}, {23'd0, C_FREEZE});
    check("dw_c3_dwait", {31'd0, dwait}, 32'd1);
    tick();
    dhit = 1'b1;
    #1;
    check("dw_c4_ctrl", {23'd0, ctrl}, {23'd0, C_ADV});
    check("dw_c4_dwait", {31'd0, dwait}, 32'd1);
    tick();
    check("dw_stall_cnt", stall_cnt, 32'd5);
    idle_inputs();
    #1;
    check("dw_back_run", {31'd0, dwait}, 32'd0);
    tick();

    // T4: branch beats jump, then jump alone, then imiss
    mem_brtaken = 1'b1; ex_jump = 1'b1;
    #1;
    check("br_jmp_ctrl", {23'd0, ctrl}, {23'd0, C_BRANCH});
    tick();
    check("br_flush_cnt", flush_cnt, 32'd1);
    mem_brtaken = 1'b0;
    #1;
    check("jmp_ctrl", {23'd0, ctrl}, {23'd0, C_JUMP});
    tick();
    check("jmp_flush_cnt", flush_cnt, 32'd2);
    idle_inputs();
    ihit = 1'b0;
    #1;
    check("imiss_ctrl", {23'd0, ctrl}, {23'd0, C_IMISS});
    tick();
    check("imiss_stall_cnt", stall_cnt, 32'd6);
    idle_inputs();

    // T5: branch under a dmem wait is deferred until dhit
    mem_dreq = 1'b1; dhit = 1'b0; mem_brtaken = 1'b1;
    #1;
    check("brw_frz_ctrl", {23'd0, ctrl}, {23'd0, C_FREEZE});
    tick();
    check("brw_frz_flush_cnt", flush_cnt, 32'd2);
    dhit = 1'b1;
    #1;
    check("brw_hit_ctrl", {23'd0, ctrl}, {23'd0, C_BRANCH});
    tick();
    check("brw_flush_cnt", flush_cnt, 32'd3);
    check("brw_stall_cnt", stall_cnt, 32'd7);
    idle_inputs();

    // T6: halt drain, then ten cycles of random inputs in HALT
    wb_halt = 1'b1;
    #1;
    check("halt_ctrl", {23'd0, ctrl}, {23'd0, C_HALT});
    check("halt_not_yet", {31'd0, halted}, 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      ihit = 1'($urandom); dhit = 1'($urandom); mem_dreq = 1'($urandom);
      mem_brtaken = 1'($urandom); ex_jump = 1'($urandom);
      ex_memread = 1'($urandom); wb_halt = 1'($urandom);
      ex_rt = 5'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
      #1;
      check("halt_halted", {31'd0, halted}, 32'd1);
      check("halt_frozen", {23'd0, ctrl}, {23'd0, C_FREEZE});
      tick();
      check("halt_stall_cnt", stall_cnt, 32'd8);
      check("halt_flush_cnt", flush_cnt, 32'd3);
    end
    idle_inputs();
    RST = 1'b1;
    #1;
    check("halt_rst_ctrl", {23'd0, ctrl}, {23'd0, C_RESET});
    check("halt_rst_halted", {31'd0, halted}, 32'd0);
    tick();
    RST = 1'b0;
    #1;
    check("post_rst_stall", stall_cnt, 32'd0);
    check("post_rst_flush", flush_cnt, 32'd0);
    check("post_rst_halted", {31'd0, halted}, 32'd0);
    check("post_rst_ctrl", {23'd0, ctrl}, {23'd0, C_ADV});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
